// File: rtl/vga_arb_pkg.sv
// rtl/vga_arb_pkg.sv - shared owner encoding and parameter defaults for the VGA/GPU memory arbiter
package vga_arb_pkg;

    typedef enum logic {
        OWNER_VGA = 1'b0,
        OWNER_GPU = 1'b1
    } owner_e;

    localparam int unsigned DEF_MAX_OUTSTANDING = 8;
    localparam int unsigned DEF_STARVE_LIMIT    = 16;

endpackage

// File: rtl/vga_arb_tag_fifo.sv
// rtl/vga_arb_tag_fifo.sv - in-order 1-bit owner tag FIFO tracking reads in flight
module vga_arb_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          push_data,
    input  logic          pop,
    output logic          pop_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A pop frees the head slot this cycle, so a push into a full FIFO is allowed alongside it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vga_mem_arbiter.sv
// rtl/vga_mem_arbiter.sv - zero-latency VGA/GPU arbiter onto one pipelined memory port
// Optional starvation guard: define VGA_ARB_STARVE_GUARD_EN.
module vga_mem_arbiter
    import vga_arb_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int unsigned STARVE_LIMIT    = DEF_STARVE_LIMIT
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] vga_address,
    input  logic        vga_read,
    output logic [31:0] vga_read_data,
    output logic        vga_wait_request,
    output logic        vga_read_data_valid,

    input  logic [31:0] gpu_address,
    input  logic        gpu_read,
    input  logic        gpu_write,
    input  logic [31:0] gpu_write_data,
    input  logic [3:0]  gpu_byte_enable,
    output logic [31:0] gpu_read_data,
    output logic        gpu_wait_request,
    output logic        gpu_read_data_valid,

    output logic [31:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_write_data,
    output logic [3:0]  master_byte_enable,
    input  logic [31:0] master_read_data,
    input  logic        master_wait_request,
    input  logic        master_read_data_valid,

    output logic        err_orphan
);

    localparam int unsigned CW    = $clog2(MAX_OUTSTANDING);
    localparam logic [CW:0] MAX_C = (CW + 1)'(MAX_OUTSTANDING);

    if (MAX_OUTSTANDING < 2 || MAX_OUTSTANDING > 32 ||
        (MAX_OUTSTANDING & (MAX_OUTSTANDING - 1)) != 0) begin : g_bad_max
        $error("MAX_OUTSTANDING must be a power of two in 2..32");
    end
    if (STARVE_LIMIT < 1) begin : g_bad_starve
        $error("STARVE_LIMIT must be at least 1");
    end

    logic [CW:0] fifo_count;
    logic        fifo_full, fifo_empty, fifo_head;
    logic        read_ok, vga_req, gpu_req, force_gpu;
    logic        grant_valid;
    owner_e      grant_owner;
    logic        lock_q, lock_d;
    owner_e      lock_owner_q, lock_owner_d;
    logic        err_orphan_q, err_orphan_d;
    logic        accept_read, pop_valid;

    // Eligibility uses the registered count, so a same-cycle data return does not open a slot.
    assign read_ok = (fifo_count < MAX_C);
    assign vga_req = vga_read & read_ok;
    assign gpu_req = gpu_write | (gpu_read & read_ok);

    always_comb begin
        grant_valid = 1'b0;
        grant_owner = OWNER_VGA;
        if (lock_q) begin
            grant_valid = 1'b1;
            grant_owner = lock_owner_q;
        end else if (force_gpu && gpu_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_GPU;
        end else if (vga_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_VGA;
        end else if (gpu_req) begin
            grant_valid = 1'b1;
            grant_owner = OWNER_GPU;
        end
    end

    always_comb begin
        master_address     = '0;
        master_read        = 1'b0;
        master_write       = 1'b0;
        master_write_data  = '0;
        master_byte_enable = '0;
        if (rst_n && grant_valid) begin
            if (grant_owner == OWNER_VGA) begin
                master_address     = vga_address;
                master_read        = vga_read;
                master_byte_enable = 4'hF;
            end else begin
                master_address     = gpu_address;
                master_write       = gpu_write;
                master_read        = gpu_read & ~gpu_write;
                master_write_data  = gpu_write_data;
                master_byte_enable = gpu_byte_enable;
            end
        end
    end

    assign vga_wait_request = ~(rst_n && grant_valid && grant_owner == OWNER_VGA) | master_wait_request;
    assign gpu_wait_request = ~(rst_n && grant_valid && grant_owner == OWNER_GPU) | master_wait_request;

    assign accept_read = master_read & ~master_wait_request;
    assign pop_valid   = rst_n & master_read_data_valid & ~fifo_empty;

    assign vga_read_data       = master_read_data;
    assign gpu_read_data       = master_read_data;
    assign vga_read_data_valid = pop_valid & (fifo_head == OWNER_VGA);
    assign gpu_read_data_valid = pop_valid & (fifo_head == OWNER_GPU);
    assign err_orphan          = err_orphan_q;

    always_comb begin
        lock_d       = (master_read | master_write) & master_wait_request;
        lock_owner_d = grant_owner;
        err_orphan_d = err_orphan_q | (master_read_data_valid & fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q       <= 1'b0;
            lock_owner_q <= OWNER_VGA;
            err_orphan_q <= 1'b0;
        end else begin
            lock_q       <= lock_d;
            lock_owner_q <= lock_owner_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    vga_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept_read & ~fifo_full),
        .push_data (grant_owner == OWNER_GPU),
        .pop       (pop_valid),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef VGA_ARB_STARVE_GUARD_EN
    localparam int unsigned SW        = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt_q, starve_cnt_d;
    logic          gpu_pending;

    assign gpu_pending = gpu_read | gpu_write;
    assign force_gpu   = (starve_cnt_q >= LIMIT_C);

    // Only fresh (unlocked) VGA wins count; a stalled VGA command is one grant, not many.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if ((grant_valid && grant_owner == OWNER_GPU) || !gpu_pending) begin
            starve_cnt_d = '0;
        end else if (!lock_q && grant_valid && grant_owner == OWNER_VGA && !force_gpu) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    assign force_gpu = 1'b0;
`endif

endmodule

// File: doc/vga_mem_arbiter.md
VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 8, max reads in flight on the shared port (power of two, 2..32).
REQ-002 SHALL have parameter STARVE_LIMIT, default 16, consecutive VGA grants before a forced GPU grant (starvation guard only).
REQ-003 SHALL have port clk  in  1  system clock; only clock.
REQ-004 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have VGA slave ports: vga_address in 32, vga_read in 1, vga_read_data out 32, vga_wait_request out 1, vga_read_data_valid out 1 (read-only requester).
REQ-006 SHALL have GPU slave ports: gpu_address in 32, gpu_read in 1, gpu_write in 1, gpu_write_data in 32, gpu_byte_enable in 4, gpu_read_data out 32, gpu_wait_request out 1, gpu_read_data_valid out 1.
REQ-007 SHALL have shared master ports: master_address out 32, master_read out 1, master_write out 1, master_write_data out 32, master_byte_enable out 4, master_read_data in 32, master_wait_request in 1, master_read_data_valid in 1.
REQ-008 SHALL have port err_orphan  out  1  sticky: read data arrived with no outstanding read.

Function
REQ-009 SHALL arbitrate combinationally: command reaches master_* same cycle as granted request; zero added latency.
REQ-010 SHALL lock grant in a register while master_read|master_write is high and master_wait_request is high; locked owner's command passes unchanged until accepted.
REQ-011 SHALL, when unlocked, grant VGA if vga_read is high and read-eligible, else GPU if gpu_read (read-eligible) or gpu_write is high, else idle (master_read=master_write=0).
REQ-012 SHALL define read-eligible as outstanding count < MAX_OUTSTANDING, evaluated before any same-cycle pop.
REQ-013 SHALL drive wait_request=1 to every non-granted requester and pass master_wait_request to the granted one.
REQ-014 SHALL treat gpu_read and gpu_write both high as illegal and forward the write only.
REQ-015 SHALL, on read acceptance (master_read & !master_wait_request), push owner tag (VGA/GPU) into in-order tag FIFO; writes push nothing.
REQ-016 SHALL, on master_read_data_valid, pop head tag and assert the owner's read_data_valid that cycle; master_read_data fans out to both read_data outputs.
REQ-017 SHALL support push and pop in the same cycle, count unchanged.
REQ-018 SHALL, on master_read_data_valid with FIFO empty, assert neither requester valid and set err_orphan until reset.

Reset
REQ-019 SHALL, during rst_n low, drive master_read=master_write=0, both read_data_valid=0, both wait_request=1, err_orphan=0, FIFO empty, grant unlocked, starvation counter 0.
REQ-020 SHALL discard in-flight tags on mid-operation reset; post-reset read data with empty FIFO sets err_orphan per REQ-018.

Configuration
REQ-021 SHALL, with VGA_ARB_STARVE_GUARD_EN defined, count consecutive VGA grants while a GPU request is pending and, at STARVE_LIMIT, give the next unlocked arbitration to an eligible GPU request, then clear the counter; counter also clears on any GPU grant.
REQ-022 SHALL, without VGA_ARB_STARVE_GUARD_EN, use strict VGA priority with no counter logic.

Structure
REQ-023 SHALL take owner enumeration (OWNER_VGA=0, OWNER_GPU=1) and parameter defaults from shared package vga_arb_pkg.
REQ-024 SHALL implement tag FIFO as sub-module vga_arb_tag_fifo (1-bit data, depth MAX_OUTSTANDING, count/full/empty outputs).

Verification
REQ-025 SHALL cover: vga_read and gpu_read high same cycle, master_wait_request=0 -> master_address=vga_address; gpu_wait_request=1; GPU granted next cycle.
REQ-026 SHALL cover: GPU write to 0x0000_1000 held 3 cycles by master_wait_request, vga_read rises cycle 1 -> write stays on master port until accepted; VGA granted after.
REQ-027 SHALL cover: reads accepted in order VGA,GPU,VGA, three master_read_data_valid pulses -> valids routed VGA,GPU,VGA with matching data.
REQ-028 SHALL cover: 8 reads outstanding, 9th vga_read -> vga_wait_request=1, master_read=0; one data return -> 9th read issued next cycle.
REQ-029 SHALL cover: guard enabled, STARVE_LIMIT=4, VGA and GPU reading continuously -> grant pattern V,V,V,V,G repeating; guard disabled -> GPU never granted.
REQ-030 SHALL cover: rst_n pulsed low with 3 reads outstanding, then master_read_data_valid -> no requester valid, err_orphan=1.
